// File: rtl/alu_exec_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_exec_stage_pkg
//   Shared definitions for the ALU execute stage: the ALU operation codes used
//   by the decoder, and the payload carried alongside each result through the
//   stage's two-entry output buffer.
// -----------------------------------------------------------------------------
package alu_exec_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int OP_W   = 4;

    // Operation codes as emitted by the ALU decoder. Codes 11..14 are
    // unassigned and, like ALU_XXX, produce a zero result.
    typedef enum logic [OP_W-1:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLT    = 4'd5,
        ALU_SLTU   = 4'd6,
        ALU_SLL    = 4'd7,
        ALU_SRA    = 4'd8,
        ALU_SRL    = 4'd9,
        ALU_COPY_B = 4'd10,
        ALU_XXX    = 4'd15
    } alu_op_e;

    // One buffered result with its writeback tag.
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_W-1:0]  rd;
        logic              we;
    } exec_entry_t;

    localparam exec_entry_t ENTRY_ZERO = '{result: '0, rd: '0, we: 1'b0};

endpackage

// File: rtl/alu_exec_stage_alu.sv
// -----------------------------------------------------------------------------
// alu_exec_stage_alu
//   Purely combinational ALU datapath.
//   Ports:
//     a      in  32  operand A
//     b      in  32  operand B (shift amount taken from b[4:0])
//     alu_op in   4  operation code (alu_op_e)
//     out    out 32  result; zero for ALU_XXX and unassigned codes
// -----------------------------------------------------------------------------
module alu_exec_stage_alu
    import alu_exec_stage_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] out
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        out = '0;
        case (alu_op)
            ALU_ADD:    out = a + b;
            ALU_SUB:    out = a - b;
            ALU_AND:    out = a & b;
            ALU_OR:     out = a | b;
            ALU_XOR:    out = a ^ b;
            ALU_SLT:    out = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLTU:   out = {31'd0, (a < b)};
            ALU_SLL:    out = a << shamt;
            ALU_SRA:    out = $unsigned($signed(a) >>> shamt);
            ALU_SRL:    out = a >> shamt;
            ALU_COPY_B: out = b;
            default:    out = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//   Execute stage: one ALU operation per accepted input, result registered
//   with one cycle of latency, followed by a two-entry (main + skid) buffer so
//   in_ready never depends combinationally on out_ready.
//
//   Handshake: a transfer happens on a port in a cycle where valid && ready
//   are both high at the rising edge. A producer holding valid keeps its
//   payload stable until the transfer; out_* is held stable while
//   out_valid && !out_ready.
//
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     flush                     drop both buffered results and any same-cycle input
//     in_valid / in_ready       upstream handshake
//     in_aluop, in_a, in_b      operation and operands
//     in_rd, in_we              writeback tag carried with the result
//     out_valid / out_ready     downstream handshake
//     out_result, out_rd, out_we  buffered result and its tag
// -----------------------------------------------------------------------------
module alu_exec_stage
    import alu_exec_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_aluop,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_we
);

    logic        main_valid;
    logic        skid_valid;
    exec_entry_t main_q;
    exec_entry_t skid_q;

    logic [DATA_W-1:0] alu_out;
    exec_entry_t       new_entry;
    logic              accept;
    logic              main_free;

    alu_exec_stage_alu u_alu (
        .a      (in_a),
        .b      (in_b),
        .alu_op (in_aluop),
        .out    (alu_out)
    );

    assign new_entry = '{result: alu_out, rd: in_rd, we: in_we};

    // in_ready is a pure function of a flop, so no path from out_ready.
    assign in_ready  = !skid_valid;
    assign accept    = in_valid && in_ready;
    // Main register can take a new entry this cycle: empty, or draining.
    assign main_free = !main_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= ENTRY_ZERO;
            skid_q     <= ENTRY_ZERO;
        end else if (flush) begin
            // Flush wins over accepts and drains; payloads are left as-is.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                // Older skid entry goes first; in_ready is low, so no accept
                // can happen in this cycle.
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= new_entry;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            // Main is stalled: park the new result in the skid register.
            skid_q     <= new_entry;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid  = main_valid;
    assign out_result = main_q.result;
    assign out_rd     = main_q.rd;
    assign out_we     = main_q.we;

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_aluop;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        in_we;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we;

    int n_checks;
    int n_fail;
    logic [31:0] exp_q[$];

    alu_exec_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_aluop   (in_aluop),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_rd      (in_rd),
        .in_we      (in_we),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_we     (out_we)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    // Inputs change just after posedge, so negedge sees the values the next
    // edge will act on.
    always @(negedge clk) begin
        if (out_valid && out_ready && !flush && !rst) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_delivery", out_result, 32'hDEADBEEF);
            end else begin
                check_eq("sb_result", out_result, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic we, input logic [31:0] exp);
        in_valid = 1'b1;
        in_aluop = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        in_we    = we;
        @(negedge clk);
        if (in_ready) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        drive_op(op, a, b, 5'd7, 1'b1, exp);
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_eq(tag, out_result, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_aluop  = 4'd0;
        in_a      = '0;
        in_b      = '0;
        in_rd     = '0;
        in_we     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_result", out_result, 32'd0);
        rst = 1'b0;
        step();

        // SUB with latency 1
        drive_op(4'd1, 32'd5, 32'd7, 5'd3, 1'b1, 32'hFFFFFFFE);
        check_eq("sub_valid", {31'd0, out_valid}, 32'd1);
        check_eq("sub_result", out_result, 32'hFFFFFFFE);
        check_eq("sub_rd", {27'd0, out_rd}, 32'd3);
        check_eq("sub_we", {31'd0, out_we}, 32'd1);

        // Back-to-back ops with downstream always ready
        run_vec("sra",    4'd8,  32'h80000000, 32'h24, 32'hF8000000);
        run_vec("srl",    4'd9,  32'h80000000, 32'h24, 32'h08000000);
        run_vec("slt",    4'd5,  32'hFFFFFFFF, 32'd1,  32'd1);
        run_vec("sltu",   4'd6,  32'hFFFFFFFF, 32'd1,  32'd0);
        run_vec("copy_b", 4'd10, 32'hAAAAAAAA, 32'h12345000, 32'h12345000);
        run_vec("op12",   4'd12, 32'h11111111, 32'h22222222, 32'd0);
        run_vec("xxx",    4'd15, 32'h11111111, 32'h22222222, 32'd0);
        run_vec("add",    4'd0,  32'hFFFFFFFF, 32'd2,  32'd1);
        run_vec("and",    4'd2,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000);
        run_vec("or",     4'd3,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0);
        run_vec("xor",    4'd4,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0);
        run_vec("sll",    4'd7,  32'd1, 32'h3F, 32'h80000000);
        step();
        check_eq("idle_valid", {31'd0, out_valid}, 32'd0);
        check_eq("idle_sb_empty", exp_q.size(), 32'd0);

        // Stall: three ops, only two accepted
        out_ready = 1'b0;
        drive_op(4'd0, 32'd1, 32'd1, 5'd1, 1'b1, 32'd2);
        check_eq("stall1_in_ready", {31'd0, in_ready}, 32'd1);
        drive_op(4'd0, 32'd2, 32'd2, 5'd2, 1'b0, 32'd4);
        check_eq("stall2_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("stall2_result", out_result, 32'd2);
        drive_op(4'd0, 32'd3, 32'd3, 5'd3, 1'b1, 32'd6);
        check_eq("stall3_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("stall3_result", out_result, 32'd2);
        check_eq("stall3_rd", {27'd0, out_rd}, 32'd1);
        out_ready = 1'b1;
        step();
        check_eq("drain1_result", out_result, 32'd4);
        check_eq("drain1_rd", {27'd0, out_rd}, 32'd2);
        check_eq("drain1_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check_eq("drain2_valid", {31'd0, out_valid}, 32'd0);
        check_eq("drain_sb_empty", exp_q.size(), 32'd0);

        // Flush with both entries full and in_valid high
        out_ready = 1'b0;
        drive_op(4'd0, 32'd10, 32'd1, 5'd4, 1'b1, 32'd11);
        drive_op(4'd0, 32'd20, 32'd1, 5'd5, 1'b1, 32'd21);
        in_valid  = 1'b1;
        in_aluop  = 4'd0;
        in_a      = 32'd30;
        in_b      = 32'd1;
        flush     = 1'b1;
        out_ready = 1'b1;
        exp_q.delete();
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check_eq("flush_after_valid", {31'd0, out_valid}, 32'd0);

        // Flush overrides a same-cycle accept while in_ready is high
        out_ready = 1'b0;
        drive_op(4'd0, 32'd40, 32'd1, 5'd6, 1'b1, 32'd41);
        in_valid = 1'b1;
        in_a     = 32'd50;
        flush    = 1'b1;
        exp_q.delete();
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("flush2_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush2_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check_eq("flush2_after_valid", {31'd0, out_valid}, 32'd0);

        // Reset mid-stall with both entries full
        out_ready = 1'b0;
        drive_op(4'd3, 32'hF0, 32'h0F, 5'd9, 1'b1, 32'hFF);
        drive_op(4'd3, 32'hA0, 32'h05, 5'd10, 1'b1, 32'hA5);
        check_eq("prerst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("midrst_out_result", out_result, 32'd0);
        check_eq("midrst_out_rd", {27'd0, out_rd}, 32'd0);
        check_eq("midrst_out_we", {31'd0, out_we}, 32'd0);
        out_ready = 1'b1;
        step();
        check_eq("postrst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("final_sb_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port flush  input  1  discard all held and in-flight results.
REQ-004 SHALL have port in_valid  input  1  upstream presents an operation.
REQ-005 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-006 SHALL have port in_aluop  input  4  ALU operation code, as produced by the ALU decoder.
REQ-007 SHALL have ports in_a, in_b  input  32 each  operands A and B.
REQ-008 SHALL have ports in_rd (input, 5, destination register) and in_we (input, 1, writeback enable).
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-011 SHALL have ports out_result (output, 32), out_rd (output, 5) and out_we (output, 1), all carried with the result.

Function
REQ-012 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-013 SHALL compute: ADD a+b; SUB a-b (mod 2^32); AND, OR, XOR bitwise; SLT signed a<b ? 1 : 0; SLTU unsigned a<b ? 1 : 0; SLL a<<b[4:0]; SRL logical a>>b[4:0]; SRA arithmetic a>>>b[4:0]; COPY_B b.
REQ-014 SHALL produce result 0 for ALU_XXX and for every unassigned code.
REQ-015 SHALL hold two entries: a main output register driving the out_* ports, and a skid register.
REQ-016 SHALL register the result with latency 1: an input accepted in cycle N appears on out_* in cycle N+1 when the main register was empty or drained in cycle N.
REQ-017 SHALL drive in_ready = !skid_valid, from a register with no combinational path from out_ready.
REQ-018 SHALL write an accepted input to the skid register when the main register is valid and not draining; in_ready then falls in the next cycle.
REQ-019 SHALL move the skid entry into the main register when the main register drains; the next new input waits behind it, preserving order.
REQ-020 SHALL, when the main register drains and a new input arrives while the skid register is empty, load the new input into the main register in the same cycle.
REQ-021 SHALL keep out_* stable while out_valid && !out_ready.
REQ-022 SHALL, on flush, clear both valid bits in the next cycle; flush overrides any same-cycle accept, and out_ready is ignored that cycle.
REQ-023 SHALL set in_ready = 1 in the cycle after a flush.
REQ-024 SHALL never drop or duplicate a result: accepted-input count = delivered + held + flushed.

Reset
REQ-025 SHALL, on rst, clear out_valid and skid_valid, set in_ready = 1, and drive out_result = 0, out_rd = 0, out_we = 0.
REQ-026 SHALL give rst priority over flush and over all transfers, including a reset asserted mid-stall.

Structure
REQ-027 SHALL take ALU op codes from the shared header ALUop.vh: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRA 8, SRL 9, COPY_B 10, XXX 15.
REQ-028 SHALL place the combinational datapath in one sub-module, ALU (A, B, ALUop -> Out), with the buffering logic in alu_exec_stage.

Verification
REQ-029 SHALL check: out_ready=1, one op SUB a=5 b=7 -> next cycle out_valid=1, out_result=0xFFFFFFFE.
REQ-030 SHALL check: SRA a=0x80000000 b=0x24, then SRL with the same operands -> results 0xF8000000 then 0x08000000 (shift amount 4).
REQ-031 SHALL check: SLT a=0xFFFFFFFF b=1 -> 1; SLTU with the same operands -> 0; COPY_B b=0x12345000 -> 0x12345000; op 12 -> 0.
REQ-032 SHALL check: out_ready=0, three back-to-back ops -> two accepted, in_ready=0 from cycle 2; then out_ready=1 -> results delivered in order, in_ready returns to 1.
REQ-033 SHALL check: flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and nothing delivered.
REQ-034 SHALL check: rst asserted mid-stall with both entries full -> next cycle all outputs at the REQ-025 reset values.
